// File: rtl/pf_fetch.sv
// Fetch-request stage: owns the fetch PC and runs a one-outstanding request/data
// handshake with the instruction cache, then hands each word plus its PC to IF.
module pf_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] NPC,
    input  logic        Instr_Flush,
    output logic [31:0] PC,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    logic [1:0]  state_r;
    logic [1:0]  state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] inst_r;
    logic [31:0] inst_s;

    // Next-state, next-PC and instruction-register selection; a flush always wins.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        inst_s  = inst_r;
        case (state_r)
            ST_REQ: begin
                if (Instr_Flush) begin
                    pc_s    = NPC;
                    // A request accepted in the flush cycle is stale; its data must be swallowed.
                    state_s = inst_addr_ok ? ST_DROP : ST_REQ;
                end else if (inst_addr_ok) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (Instr_Flush) begin
                    pc_s    = NPC;
                    state_s = inst_data_ok ? ST_REQ : ST_DROP;
                end else if (inst_data_ok) begin
                    inst_s  = inst_rdata;
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (Instr_Flush || out_ready) begin
                    pc_s    = NPC;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DROP: begin
                if (Instr_Flush) begin
                    pc_s = NPC;
                end else begin
                    pc_s = pc_r;
                end
                // The cancelled request's data ends the drop even if a new flush arrives with it.
                if (inst_data_ok) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: begin
                state_s = ST_REQ;
            end
        endcase
    end

    // State, PC and instruction register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_REQ;
            pc_r    <= RESET_PC;
            inst_r  <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            inst_r  <= inst_s;
        end
    end

    assign PC        = pc_r;
    assign inst_addr = pc_r;
    assign inst_req  = (state_r == ST_REQ);
    assign out_valid = (state_r == ST_HOLD);
    assign out_pc    = pc_r;
    assign out_inst  = inst_r;

endmodule
